// File: rtl/decode_stage_if.sv
// Fetch-to-execute handshake bundle for decode_stage.
// Op vector width follows DECODE_RV32I_EXT_EN (13 ops when defined, 8 otherwise).
interface decode_stage_if;
`ifdef DECODE_RV32I_EXT_EN
    localparam int NOP = 13;
`else
    localparam int NOP = 8;
`endif

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [31:0]     in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_pc;
    logic [NOP-1:0]  out_op;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [31:0]     out_imm;
    logic            out_illegal;
    logic            out_ebreak;

    // Master drives instructions in and accepts decoded bundles.
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2,
               out_imm, out_illegal, out_ebreak
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2,
               out_imm, out_illegal, out_ebreak
    );
endinterface

// File: rtl/decode_stage.sv
// miniRV registered decode stage with ebreak halt FSM and saturating illegal counter.
// Optional macro DECODE_RV32I_EXT_EN adds sub/and/or/beq/jal decoding.
module decode_stage #(
    parameter int CNT_W           = 8,
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             resume,
    input  logic             cnt_clr,
    output logic             halted,
    output logic [CNT_W-1:0] illegal_cnt,
    decode_stage_if.slave    bus
);

`ifdef DECODE_RV32I_EXT_EN
    localparam int NOP = 13;
`else
    localparam int NOP = 8;
`endif

    localparam int OP_ADD  = 0;
    localparam int OP_ADDI = 1;
    localparam int OP_LUI  = 2;
    localparam int OP_LW   = 3;
    localparam int OP_LBU  = 4;
    localparam int OP_SW   = 5;
    localparam int OP_SB   = 6;
    localparam int OP_JALR = 7;
`ifdef DECODE_RV32I_EXT_EN
    localparam int OP_SUB  = 8;
    localparam int OP_AND  = 9;
    localparam int OP_OR   = 10;
    localparam int OP_BEQ  = 11;
    localparam int OP_JAL  = 12;
`endif

    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

    typedef enum logic {RUN, HALTED} state_t;

    state_t state_q, state_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    assign opcode = bus.in_instr[6:0];
    assign f3     = bus.in_instr[14:12];
    assign f7     = bus.in_instr[31:25];

    logic [NOP-1:0]     op_p0;
    logic signed [31:0] imm_p0;
    logic               illegal_p0;
    logic               ebreak_p0;

    logic signed [31:0] imm_i, imm_s, imm_u;
`ifdef DECODE_RV32I_EXT_EN
    logic signed [31:0] imm_b, imm_j;
`endif

    always_comb begin
        imm_i = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
        imm_s = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
        imm_u = {bus.in_instr[31:12], 12'b0};
`ifdef DECODE_RV32I_EXT_EN
        imm_b = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                 bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
        imm_j = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                 bus.in_instr[20], bus.in_instr[30:21], 1'b0};
`endif
    end

    always_comb begin
        op_p0 = '0;
        case (opcode)
            7'b0110011: begin
                if (f3 == 3'b000 && f7 == 7'b0000000) op_p0[OP_ADD] = 1'b1;
`ifdef DECODE_RV32I_EXT_EN
                if (f3 == 3'b000 && f7 == 7'b0100000) op_p0[OP_SUB] = 1'b1;
                if (f3 == 3'b111 && f7 == 7'b0000000) op_p0[OP_AND] = 1'b1;
                if (f3 == 3'b110 && f7 == 7'b0000000) op_p0[OP_OR]  = 1'b1;
`endif
            end
            7'b0010011: if (f3 == 3'b000) op_p0[OP_ADDI] = 1'b1;
            7'b0110111: op_p0[OP_LUI] = 1'b1;
            7'b0000011: begin
                if (f3 == 3'b010) op_p0[OP_LW]  = 1'b1;
                if (f3 == 3'b100) op_p0[OP_LBU] = 1'b1;
            end
            7'b0100011: begin
                if (f3 == 3'b010) op_p0[OP_SW] = 1'b1;
                if (f3 == 3'b000) op_p0[OP_SB] = 1'b1;
            end
            7'b1100111: if (f3 == 3'b000) op_p0[OP_JALR] = 1'b1;
`ifdef DECODE_RV32I_EXT_EN
            7'b1100011: if (f3 == 3'b000) op_p0[OP_BEQ] = 1'b1;
            7'b1101111: op_p0[OP_JAL] = 1'b1;
`endif
            default: op_p0 = '0;
        endcase
    end

    assign ebreak_p0  = (bus.in_instr == EBREAK_WORD);
    assign illegal_p0 = (op_p0 == '0) & ~ebreak_p0;

    // Illegal and ebreak words fall through every branch and leave imm at zero.
    always_comb begin
        imm_p0 = '0;
        if (op_p0[OP_ADDI] | op_p0[OP_LW] | op_p0[OP_LBU] | op_p0[OP_JALR])
            imm_p0 = imm_i;
        else if (op_p0[OP_SW] | op_p0[OP_SB])
            imm_p0 = imm_s;
        else if (op_p0[OP_LUI])
            imm_p0 = imm_u;
`ifdef DECODE_RV32I_EXT_EN
        else if (op_p0[OP_BEQ])
            imm_p0 = imm_b;
        else if (op_p0[OP_JAL])
            imm_p0 = imm_j;
`endif
    end

    logic accept;
    logic vld_p1;

    assign bus.in_ready = (~vld_p1 | bus.out_ready) & (state_q == RUN);
    assign accept       = bus.in_valid & bus.in_ready;

    // ---- stage p0 -> p1: output register ----
    logic [31:0]        pc_p1;
    logic [NOP-1:0]     op_p1;
    logic [4:0]         rd_p1, rs1_p1, rs2_p1;
    logic signed [31:0] imm_p1;
    logic               illegal_p1, ebreak_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            pc_p1      <= '0;
            op_p1      <= '0;
            rd_p1      <= '0;
            rs1_p1     <= '0;
            rs2_p1     <= '0;
            imm_p1     <= '0;
            illegal_p1 <= 1'b0;
            ebreak_p1  <= 1'b0;
        end else if (accept) begin
            vld_p1     <= 1'b1;
            pc_p1      <= bus.in_pc;
            op_p1      <= op_p0;
            rd_p1      <= bus.in_instr[11:7];
            rs1_p1     <= bus.in_instr[19:15];
            rs2_p1     <= bus.in_instr[24:20];
            imm_p1     <= imm_p0;
            illegal_p1 <= illegal_p0;
            ebreak_p1  <= ebreak_p0;
        end else if (bus.out_ready) begin
            vld_p1     <= 1'b0;
        end
    end

    assign bus.out_valid   = vld_p1;
    assign bus.out_pc      = pc_p1;
    assign bus.out_op      = op_p1;
    assign bus.out_rd      = rd_p1;
    assign bus.out_rs1     = rs1_p1;
    assign bus.out_rs2     = rs2_p1;
    assign bus.out_imm     = imm_p1;
    assign bus.out_illegal = illegal_p1;
    assign bus.out_ebreak  = ebreak_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (accept && (ebreak_p0 || (HALT_ON_ILLEGAL && illegal_p0)))
                    state_d = HALTED;
            end
            HALTED: begin
                if (resume) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign halted = (state_q == HALTED);

    always_ff @(posedge clk) begin
        if (!rst_n)                   illegal_cnt <= '0;
        else if (cnt_clr)             illegal_cnt <= '0;
        else if (accept && illegal_p0) illegal_cnt <= sat_inc(illegal_cnt);
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a scoreboard of expected decoded bundles.
module tb_decode_stage;

`ifdef DECODE_RV32I_EXT_EN
    localparam int NOP = 13;
`else
    localparam int NOP = 8;
`endif

    typedef struct packed {
        logic [NOP-1:0] op;
        logic [4:0]     rd;
        logic [4:0]     rs1;
        logic [4:0]     rs2;
        logic [31:0]    imm;
        logic [31:0]    pc;
        logic           ill;
        logic           ebr;
    } bundle_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       resume, cnt_clr, halted;
    logic [7:0] illegal_cnt;
    logic       resume2, cnt_clr2, halted2;
    logic [7:0] illegal_cnt2;

    decode_stage_if ifc ();
    decode_stage_if ifc2 ();

    decode_stage #(.CNT_W(8), .HALT_ON_ILLEGAL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .resume(resume), .cnt_clr(cnt_clr),
        .halted(halted), .illegal_cnt(illegal_cnt), .bus(ifc)
    );

    decode_stage #(.CNT_W(8), .HALT_ON_ILLEGAL(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .resume(resume2), .cnt_clr(cnt_clr2),
        .halted(halted2), .illegal_cnt(illegal_cnt2), .bus(ifc2)
    );

    int tests = 0;
    int fails = 0;
    bundle_t sbq[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference decode written as a match on {f7,f3,opcode}.
    function automatic bundle_t model(input logic [31:0] i, input logic [31:0] pc);
        bundle_t b;
        logic [31:0] ii, si, ui;
        b = '0;
        b.pc = pc; b.rd = i[11:7]; b.rs1 = i[19:15]; b.rs2 = i[24:20];
        ii = {{20{i[31]}}, i[31:20]};
        si = {{20{i[31]}}, i[31:25], i[11:7]};
        ui = {i[31:12], 12'h000};
        if (i == 32'h0010_0073) b.ebr = 1'b1;
        else casez ({i[31:25], i[14:12], i[6:0]})
            17'b0000000_000_0110011: b.op[0] = 1'b1;
            17'b???????_000_0010011: begin b.op[1] = 1'b1; b.imm = ii; end
            17'b???????_???_0110111: begin b.op[2] = 1'b1; b.imm = ui; end
            17'b???????_010_0000011: begin b.op[3] = 1'b1; b.imm = ii; end
            17'b???????_100_0000011: begin b.op[4] = 1'b1; b.imm = ii; end
            17'b???????_010_0100011: begin b.op[5] = 1'b1; b.imm = si; end
            17'b???????_000_0100011: begin b.op[6] = 1'b1; b.imm = si; end
            17'b???????_000_1100111: begin b.op[7] = 1'b1; b.imm = ii; end
`ifdef DECODE_RV32I_EXT_EN
            17'b0100000_000_0110011: b.op[8] = 1'b1;
            17'b0000000_111_0110011: b.op[9] = 1'b1;
            17'b0000000_110_0110011: b.op[10] = 1'b1;
            17'b???????_000_1100011: begin
                b.op[11] = 1'b1;
                b.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            end
            17'b???????_???_1101111: begin
                b.op[12] = 1'b1;
                b.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
`endif
            default: b.ill = 1'b1;
        endcase
        return b;
    endfunction

    always @(negedge clk) begin
        if (rst_n && ifc.out_valid && ifc.out_ready) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_bundle", 64'd1, 64'd0);
            end else begin
                bundle_t e;
                e = sbq.pop_front();
                chk("sb_op", 64'(ifc.out_op), 64'(e.op));
                chk("sb_imm", 64'(ifc.out_imm), 64'(e.imm));
                chk("sb_regs", 64'({ifc.out_rd, ifc.out_rs1, ifc.out_rs2}), 64'({e.rd, e.rs1, e.rs2}));
                chk("sb_flags", 64'({ifc.out_illegal, ifc.out_ebreak}), 64'({e.ill, e.ebr}));
                chk("sb_pc", 64'(ifc.out_pc), 64'(e.pc));
            end
        end
    end

    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        int n;
        n = 0;
        ifc.in_valid = 1'b1; ifc.in_instr = ins; ifc.in_pc = pc;
        @(negedge clk);
        while (!ifc.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.in_ready) chk("send_timeout", 64'd0, 64'd1);
        else sbq.push_back(model(ins, pc));
        @(posedge clk); #1;
    endtask

    task automatic idle();
        ifc.in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] held_imm;
        rst_n = 1'b0; resume = 1'b0; cnt_clr = 1'b0;
        resume2 = 1'b0; cnt_clr2 = 1'b0;
        ifc.in_valid = 1'b0; ifc.in_instr = '0; ifc.in_pc = '0; ifc.out_ready = 1'b0;
        ifc2.in_valid = 1'b0; ifc2.in_instr = '0; ifc2.in_pc = '0; ifc2.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("rst_out_op", 64'(ifc.out_op), 64'd0);
        chk("rst_out_imm", 64'(ifc.out_imm), 64'd0);
        chk("rst_out_pc", 64'(ifc.out_pc), 64'd0);
        chk("rst_flags", 64'({ifc.out_illegal, ifc.out_ebreak}), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_cnt", 64'(illegal_cnt), 64'd0);
        chk("rst_in_ready", 64'(ifc.in_ready), 64'd1);

        // addi x1,x0,5
        ifc.out_ready = 1'b1;
        send(32'h0050_0093, 32'h100);
        chk("addi_valid", 64'(ifc.out_valid), 64'd1);
        chk("addi_op", 64'(ifc.out_op), 64'h02);
        chk("addi_rd", 64'(ifc.out_rd), 64'd1);
        chk("addi_imm", 64'(ifc.out_imm), 64'd5);
        idle();
        step();
        chk("drain_valid", 64'(ifc.out_valid), 64'd0);

        // lw x1,-4(x2) under a 3-cycle stall
        ifc.out_ready = 1'b0;
        send(32'hFFC1_2083, 32'h104);
        idle();
        held_imm = ifc.out_imm;
        chk("lw_imm", 64'(ifc.out_imm), 64'hFFFF_FFFC);
        chk("lw_op_bit3", 64'(ifc.out_op[3]), 64'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_valid", 64'(ifc.out_valid), 64'd1);
            chk("stall_imm", 64'(ifc.out_imm), 64'(held_imm));
            chk("stall_pc", 64'(ifc.out_pc), 64'h104);
            chk("stall_in_ready", 64'(ifc.in_ready), 64'd0);
        end
        ifc.out_ready = 1'b1;
        send(32'h0050_0093, 32'h108);
        chk("after_stall_op", 64'(ifc.out_op), 64'h02);
        chk("after_stall_pc", 64'(ifc.out_pc), 64'h108);

        // full-rate add, sw, lui
        send(32'h0020_81B3, 32'h10C);
        chk("add_op", 64'(ifc.out_op), 64'h01);
        chk("add_imm", 64'(ifc.out_imm), 64'd0);
        chk("add_regs", 64'({ifc.out_rd, ifc.out_rs1, ifc.out_rs2}), 64'({5'd3, 5'd1, 5'd2}));
        send(32'h0020_A423, 32'h110);
        chk("sw_valid", 64'(ifc.out_valid), 64'd1);
        chk("sw_imm", 64'(ifc.out_imm), 64'd8);
        chk("sw_op", 64'(ifc.out_op), 64'h20);
        send(32'h1234_52B7, 32'h114);
        chk("lui_imm", 64'(ifc.out_imm), 64'h1234_5000);
        chk("lui_op", 64'(ifc.out_op), 64'h04);
        idle();
        step();

        // ebreak halts, resume releases
        send(32'h0010_0073, 32'h118);
        idle();
        chk("ebreak_flag", 64'(ifc.out_ebreak), 64'd1);
        chk("ebreak_op", 64'(ifc.out_op), 64'd0);
        chk("ebreak_imm", 64'(ifc.out_imm), 64'd0);
        chk("ebreak_halted", 64'(halted), 64'd1);
        chk("halted_in_ready", 64'(ifc.in_ready), 64'd0);
        step();
        chk("halted_drained", 64'(ifc.out_valid), 64'd0);
        chk("halted_hold", 64'(halted), 64'd1);
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("resume_halted", 64'(halted), 64'd0);
        chk("resume_in_ready", 64'(ifc.in_ready), 64'd1);

        // illegal counter saturation and clear priority
        for (int k = 0; k < 260; k++) send(32'hFFFF_FFFF, 32'h200 + 32'(k) * 4);
        idle();
        chk("cnt_saturated", 64'(illegal_cnt), 64'd255);
        chk("illegal_flag", 64'(ifc.out_illegal), 64'd1);
        cnt_clr = 1'b1;
        send(32'hFFFF_FFFF, 32'h600);
        cnt_clr = 1'b0;
        idle();
        chk("cnt_clr_prio", 64'(illegal_cnt), 64'd0);
        send(32'h0000_0000, 32'h604);
        idle();
        chk("cnt_after_clr", 64'(illegal_cnt), 64'd1);
        chk("no_halt_on_illegal", 64'(halted), 64'd0);

        // HALT_ON_ILLEGAL=1 instance
        ifc2.in_valid = 1'b1; ifc2.in_instr = 32'h0000_0000; ifc2.in_pc = 32'h40;
        step();
        ifc2.in_valid = 1'b0;
        chk("hoi_illegal", 64'(ifc2.out_illegal), 64'd1);
        chk("hoi_cnt", 64'(illegal_cnt2), 64'd1);
        chk("hoi_halted", 64'(halted2), 64'd1);
        chk("hoi_in_ready", 64'(ifc2.in_ready), 64'd0);

        // sub: extension op or illegal
        send(32'h4020_8033, 32'h700);
        idle();
`ifdef DECODE_RV32I_EXT_EN
        chk("sub_op_bit8", 64'(ifc.out_op), 64'h100);
        chk("sub_illegal", 64'(ifc.out_illegal), 64'd0);
`else
        chk("sub_illegal", 64'(ifc.out_illegal), 64'd1);
        chk("sub_op", 64'(ifc.out_op), 64'd0);
`endif
        step();

        // reset with a held bundle discards it
        ifc.out_ready = 1'b0;
        send(32'h0050_0093, 32'h800);
        idle();
        chk("held_before_rst", 64'(ifc.out_valid), 64'd1);
        rst_n = 1'b0;
        sbq.delete();
        step();
        rst_n = 1'b1;
        chk("midrst_valid", 64'(ifc.out_valid), 64'd0);
        chk("midrst_op", 64'(ifc.out_op), 64'd0);
        chk("midrst_imm", 64'(ifc.out_imm), 64'd0);
        chk("midrst_cnt", 64'(illegal_cnt), 64'd0);
        chk("midrst_halted2", 64'(halted2), 64'd0);
        ifc.out_ready = 1'b1;
        step();
        chk("sb_leftover", 64'(sbq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked instruction-decode pipeline stage for the miniRV core. Sits between fetch and execute.
- Decodes one 32-bit instruction per cycle into:
  - one-hot op vector
  - register indices
  - sign-extended immediate
  - illegal/ebreak flags
- Adds an ebreak halt state machine and a saturating illegal-instruction counter. The combinational decoder it succeeds had neither.

Parameters:
- CNT_W, 8, width of illegal_cnt; saturates at 2^CNT_W-1.
- HALT_ON_ILLEGAL, 0, when 1 an accepted illegal instruction also enters HALTED.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  stage can accept
- in_instr  input  32  instruction word
- in_pc  input  32  instruction address
- resume  input  1  leave HALTED
- cnt_clr  input  1  clear illegal_cnt
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  downstream accepts
- out_pc  output  32  registered in_pc
- out_op  output  NOP  one-hot op; NOP=8 (13 with macro); bit order add,addi,lui,lw,lbu,sw,sb,jalr[,sub,and,or,beq,jal]
- out_rd  output  5  instr[11:7]
- out_rs1  output  5  instr[19:15]
- out_rs2  output  5  instr[24:20]
- out_imm  output  32  sign-extended immediate
- out_illegal  output  1  instruction not decodable
- out_ebreak  output  1  instruction == 32'h00100073
- halted  output  1  state == HALTED
- illegal_cnt  output  CNT_W  accepted illegal instruction count

Behaviour:
- Reset (rst_n low at a clk edge):
  - out_valid=0; out_op, out_imm, out_pc, out_rd, out_rs1, out_rs2, out_illegal and out_ebreak all 0.
  - halted=0; illegal_cnt=0; state=RUN.
  - Reset mid-transfer discards the held bundle.
- Handshake:
  - in_ready = (~out_valid | out_ready) & (state==RUN); combinational.
  - Accept = in_valid & in_ready. On accept, the output register loads the decoded bundle the next edge and out_valid=1.
  - out_valid&out_ready with no accept: out_valid=0 next edge.
  - While out_valid & ~out_ready, all out_* are held stable.
  - Latency 1 cycle; throughput 1/cycle with out_ready held high.
- Decode (opcode=instr[6:0], f3=instr[14:12], f7=instr[31:25]):
  - add: 0110011, f3=000, f7=0000000
  - addi: 0010011, f3=000
  - lui: 0110111
  - lw: 0000011, f3=010
  - lbu: 0000011, f3=100
  - sw: 0100011, f3=010
  - sb: 0100011, f3=000
  - jalr: 1100111, f3=000
  - ebreak: exact word match. Gives out_op=0, out_illegal=0, out_ebreak=1.
  - illegal = no op bit set & ~ebreak; out_imm forced 0 when illegal or ebreak.
- Immediate:
  - I-type {{20{i[31]}},i[31:20]} for addi, lw, lbu, jalr.
  - S-type {{20{i[31]}},i[31:25],i[11:7]} for sw, sb.
  - U-type {i[31:12],12'b0} for lui.
  - R-type 0.
- Register fields are always the raw bit slices, regardless of op.
- State machine:
  - RUN -> HALTED on accept of ebreak, or on accept of illegal when HALT_ON_ILLEGAL=1.
  - HALTED -> RUN on resume=1. resume in RUN is ignored.
  - Simultaneous resume and halting accept: not reachable (accept requires RUN).
  - The halting instruction's bundle is still presented and drained normally while HALTED.
- Counter:
  - Increments by 1 on accept of an illegal instruction; holds at all-ones when full.
  - cnt_clr has priority: clr and increment in the same cycle gives 0.

Optional Feature:
- Macro DECODE_RV32I_EXT_EN.
- Defined: NOP=13 and the following are decoded.
  - sub: 0110011, f3=000, f7=0100000
  - and: 0110011, f3=111, f7=0
  - or: 0110011, f3=110, f7=0
  - beq: 1100011, f3=000, B-imm {{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}
  - jal: 1101111, J-imm {{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}
- Undefined: NOP=8, and those encodings are illegal.

Test Plan:
- Reset release, in_valid=1, instr 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, out_op=8'b00000010, out_rd=1, out_imm=5.
- Instr 0xFFC12083 (lw x1,-4(x2)) with out_ready=0 for 3 cycles:
  - out_imm=0xFFFFFFFC, out_op bit3 set, held stable.
  - in_ready=0 during the stall.
  - Releasing out_ready drains the bundle and accepts the next instruction.
- Back-to-back 0x002081B3 (add), 0x0020A423 (sw imm 8), 0x123452B7 (lui) at full rate -> three consecutive valid bundles:
  - add: out_imm=0, rs1=1, rs2=2, rd=3.
  - sw: out_imm=8.
  - lui: out_imm=0x12345000.
- Instr 0x00100073 -> out_ebreak=1, halted=1 the following cycle, in_ready=0; resume pulse -> in_ready=1 the next cycle.
- Feed 0xFFFFFFFF 260 times with CNT_W=8 -> illegal_cnt saturates at 255; cnt_clr on the same cycle as an illegal accept -> 0.
- HALT_ON_ILLEGAL=1: instr 0x00000000 -> out_illegal=1, illegal_cnt=1, halted=1.
- With DECODE_RV32I_EXT_EN defined: instr 0x40208033 (sub) -> out_op bit8 set. Without the macro: out_illegal=1.
